// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
// Registered priority arbiter. Accepts an N-bit request vector and presents a
// single grant (index + one-hot) that is held until the consumer acknowledges
// it. The winner is chosen once, on the IDLE->GRANT edge, either by fixed
// priority (highest set index) or round-robin (first set bit scanning upward
// from an internal pointer, wrapping at N-1).
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req[N-1:0]  request vector, bit i = source i requesting
//   mode        0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   ack         consumer accepts current grant (ignored while idle)
//   gnt_valid   a grant is being presented
//   gnt_idx     index of the granted source (don't-care while gnt_valid = 0)
//   gnt_onehot  one-hot form of gnt_idx, all zero while gnt_valid = 0
// -----------------------------------------------------------------------------
module prio_arbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e         state_q,  state_d;
    logic [W-1:0]   ptr_q,    ptr_d;
    logic [W-1:0]   idx_q,    idx_d;
    logic [N-1:0]   onehot_q, onehot_d;
    logic           valid_q,  valid_d;
    logic           rr_q,     rr_d;      // grant was issued in round-robin mode

    logic [W-1:0]   fixed_idx_s;
    logic [W-1:0]   rr_idx_s;
    logic           rr_found_s;
    logic [W-1:0]   win_idx_s;

    // Winner search for both arbitration policies.
    always_comb begin
        int  j;
        logic take;
        fixed_idx_s = '0;
        rr_idx_s    = '0;
        rr_found_s  = 1'b0;
        j           = 0;
        take        = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < N; i++) begin
            fixed_idx_s = req[i] ? W'(i) : fixed_idx_s;
        end
        // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
        for (int k = 0; k < N; k++) begin
            j          = int'(ptr_q) + k;
            j          = (j >= N) ? (j - N) : j;
            take       = !rr_found_s && req[j];
            rr_idx_s   = take ? W'(j) : rr_idx_s;
            rr_found_s = rr_found_s | take;
        end
        win_idx_s = mode ? rr_idx_s : fixed_idx_s;
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d  = ST_GRANT;
                    valid_d  = 1'b1;
                    idx_d    = win_idx_s;
                    onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
                    rr_d     = mode;
                end else begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                end
            end
            ST_GRANT: begin
                // req and mode are deliberately ignored here: the grant is locked.
                if (ack) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    if (rr_q) begin
                        ptr_d = (idx_q == W'(N - 1)) ? '0 : (idx_q + W'(1));
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            rr_q     <= rr_d;
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter
// Directed-vector bench for prio_arbiter with N = 4 (dut_a) and N = 5 (dut_b).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_prio_arbiter;

    logic       clk;
    logic       rst_a, mode_a, ack_a, valid_a;
    logic [3:0] req_a, onehot_a;
    logic [1:0] idx_a;
    logic       rst_b, mode_b, ack_b, valid_b;
    logic [4:0] req_b, onehot_b;
    logic [2:0] idx_b;

    int n_vec;
    int n_err;

    prio_arbiter #(.N(4)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .mode(mode_a), .ack(ack_a),
        .gnt_valid(valid_a), .gnt_idx(idx_a), .gnt_onehot(onehot_a)
    );

    prio_arbiter #(.N(5)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .mode(mode_b), .ack(ack_b),
        .gnt_valid(valid_b), .gnt_idx(idx_b), .gnt_onehot(onehot_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a live grant on dut_a at index idx.
    task automatic exp_gnt_a(input string tag, input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk({tag, "_valid"},  {31'd0, valid_a}, 32'd1);
        chk({tag, "_idx"},    {30'd0, idx_a},   idx);
        chk({tag, "_onehot"}, {28'd0, onehot_a}, {28'd0, oh});
    endtask

    task automatic exp_idle_a(input string tag);
        chk({tag, "_valid"},  {31'd0, valid_a},  32'd0);
        chk({tag, "_onehot"}, {28'd0, onehot_a}, 32'd0);
    endtask

    task automatic exp_gnt_b(input string tag, input int idx);
        logic [4:0] oh;
        oh = 5'b00001 << idx;
        chk({tag, "_valid"},  {31'd0, valid_b},  32'd1);
        chk({tag, "_idx"},    {29'd0, idx_b},    idx);
        chk({tag, "_onehot"}, {27'd0, onehot_b}, {27'd0, oh});
    endtask

    // Complete one handshake on dut_a: ack the live grant, then drop ack.
    task automatic ack_a_once(input string tag);
        ack_a = 1'b1;
        tick();
        exp_idle_a(tag);
        ack_a = 1'b0;
    endtask

    initial begin
        logic [3:0] fx_req [5];
        int         fx_idx [5];
        int         rr_seq [6];
        int         sp_seq [4];
        fx_req = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100};
        fx_idx = '{0, 1, 2, 3, 3};
        rr_seq = '{0, 1, 2, 3, 0, 1};
        sp_seq = '{1, 3, 1, 3};
        n_vec = 0;
        n_err = 0;

        // Reset with all requests active
        rst_a = 1'b1; req_a = 4'b1111; mode_a = 1'b0; ack_a = 1'b0;
        rst_b = 1'b1; req_b = 5'b00000; mode_b = 1'b0; ack_b = 1'b0;
        tick();
        tick();
        exp_idle_a("rst");
        chk("rst_idx", {30'd0, idx_a}, 32'd0);

        // Idle with no requests
        rst_a = 1'b0; req_a = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_idle_a("idle");
        end

        // Fixed priority sweep
        for (int v = 0; v < 5; v++) begin
            req_a = fx_req[v];
            tick();
            exp_gnt_a("fixed", fx_idx[v]);
            req_a = 4'b0000;
            ack_a_once("fixed_rel");
        end

        // Round-robin with all requests held (ptr is 0: fixed grants leave it alone)
        mode_a = 1'b1; req_a = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            tick();
            exp_gnt_a("rr_full", rr_seq[g]);
            ack_a_once("rr_full_rel");
        end

        // Sparse round-robin from reset
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; req_a = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            tick();
            exp_gnt_a("rr_sparse", sp_seq[g]);
            ack_a_once("rr_sparse_rel");
        end

        // Grant lock: req changes and withdrawal are ignored until ack
        mode_a = 1'b0; req_a = 4'b0100;
        tick();
        exp_gnt_a("lock_first", 2);
        req_a = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            req_a = (c < 2) ? 4'b1000 : 4'b0000;
            tick();
            exp_gnt_a("lock_hold", 2);
        end
        req_a = 4'b1000;
        ack_a_once("lock_rel");
        tick();
        exp_gnt_a("lock_next", 3);
        ack_a_once("lock_next_rel");

        // Reset mid-grant: move ptr to 1, present grant 1, reset with ack high
        mode_a = 1'b1; req_a = 4'b1111;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        exp_gnt_a("pre_rst", 0);
        ack_a_once("pre_rst_rel");
        tick();
        exp_gnt_a("pre_rst2", 1);
        rst_a = 1'b1; ack_a = 1'b1;
        tick();
        exp_idle_a("rst_mid");
        chk("rst_mid_idx", {30'd0, idx_a}, 32'd0);
        rst_a = 1'b0; ack_a = 1'b0;
        tick();
        exp_gnt_a("post_rst", 0);
        ack_a_once("post_rst_rel");

        // ack while idle must not move ptr (ptr is 1 here)
        req_a = 4'b0000; ack_a = 1'b1;
        tick();
        tick();
        exp_idle_a("idle_ack");
        ack_a = 1'b0; req_a = 4'b1111;
        tick();
        exp_gnt_a("idle_ack_next", 1);
        ack_a_once("idle_ack_rel");

        // N = 5: round-robin wrap and mode toggling during GRANT
        rst_b = 1'b0; mode_b = 1'b1; req_b = 5'b10001;
        tick();
        exp_gnt_b("n5_first", 0);
        mode_b = 1'b0;
        tick();
        exp_gnt_b("n5_toggle0", 0);
        ack_b = 1'b1;
        tick();
        chk("n5_rel0", {31'd0, valid_b}, 32'd0);
        ack_b = 1'b0; mode_b = 1'b1;
        tick();
        exp_gnt_b("n5_second", 4);
        mode_b = 1'b0;
        tick();
        exp_gnt_b("n5_toggle1", 4);
        mode_b = 1'b1;
        tick();
        exp_gnt_b("n5_toggle2", 4);
        ack_b = 1'b1;
        tick();
        chk("n5_rel1", {31'd0, valid_b}, 32'd0);
        ack_b = 1'b0;
        tick();
        exp_gnt_b("n5_wrap", 0);
        ack_b = 1'b1;
        tick();
        chk("n5_rel2", {27'd0, onehot_b}, 32'd0);
        ack_b = 1'b0; mode_b = 1'b0;
        tick();
        exp_gnt_b("n5_fixed", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
